// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-RAM port arbiter
// (CPU MAR/MBR port versus debug readback/poke port).
package mem_arb_pkg;

  // Default widths match the external data bus.
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;

  // Width of the debug starvation counter (guard build).
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the CPU and debug requesters.
// With MEM_ARB_STARVE_GUARD_EN the starvation counter can hand the win to debug.
module mem_arb_pick
  import mem_arb_pkg::*;
`ifdef MEM_ARB_STARVE_GUARD_EN
#(
  parameter int STARVE_LIMIT = 4
)
`endif
(
  input  logic                cpu_req,
  input  logic                dbg_req,
`ifdef MEM_ARB_STARVE_GUARD_EN
  input  logic [STARVE_W-1:0] starve_cnt,
`endif
  output logic                valid,
  output owner_e              owner
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid = cpu_req | dbg_req;
    owner = OWN_CPU;
    if (dbg_req && !cpu_req) begin
      owner = OWN_DBG;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    // Debug has waited through STARVE_LIMIT CPU grants: it takes this slot.
    if (dbg_req && (starve_cnt == STARVE_W'(STARVE_LIMIT))) begin
      owner = OWN_DBG;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single data RAM: one transaction at a time,
// CPU priority. Define MEM_ARB_STARVE_GUARD_EN to bound debug starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  output logic          o_cpu_gnt,
  output logic          o_dbg_gnt,
  output logic          o_cpu_rvalid,
  output logic          o_dbg_rvalid,
  output logic [DW-1:0] o_rdata,
  output logic          o_mem_write,
  output logic          o_mem_read,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy
);

  localparam logic [1:0] RD_LAT_W = 2'(RD_LAT);

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be 1..3");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
  end

  state_e        state;
  owner_e        owner;
  logic [1:0]    lat_cnt;
  logic [1:0]    lat_dec;
  logic          rd_capture;

  logic          pick_valid;
  owner_e        pick_owner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [STARVE_W-1:0] starve_cnt;
`endif

  mem_arb_pick
`ifdef MEM_ARB_STARVE_GUARD_EN
    #(.STARVE_LIMIT(STARVE_LIMIT))
`endif
  u_pick (
    .cpu_req    (i_cpu_req),
    .dbg_req    (i_dbg_req),
`ifdef MEM_ARB_STARVE_GUARD_EN
    .starve_cnt (starve_cnt),
`endif
    .valid      (pick_valid),
    .owner      (pick_owner)
  );

  always_comb begin
    sel_we    = i_cpu_we;
    sel_addr  = i_cpu_addr;
    sel_wdata = i_cpu_wdata;
    if (pick_owner == OWN_DBG) begin
      sel_we    = i_dbg_we;
      sel_addr  = i_dbg_addr;
      sel_wdata = i_dbg_wdata;
    end
  end

  // The counter is loaded with RD_LAT at arbitration; data is captured when it steps 1 -> 0,
  // so the rvalid cycle is the one in which the counter reads zero.
  assign lat_dec    = lat_cnt - 2'd1;
  assign rd_capture = (((state == ISSUE) && o_mem_read) || (state == WAIT_RD)) && (lat_cnt == 2'd1);
  assign o_busy     = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      owner        <= OWN_CPU;
      lat_cnt      <= 2'd0;
      o_cpu_gnt    <= 1'b0;
      o_dbg_gnt    <= 1'b0;
      o_cpu_rvalid <= 1'b0;
      o_dbg_rvalid <= 1'b0;
      o_rdata      <= '0;
      o_mem_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      o_cpu_gnt    <= 1'b0;
      o_dbg_gnt    <= 1'b0;
      o_cpu_rvalid <= 1'b0;
      o_dbg_rvalid <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_read   <= 1'b0;

      if (rd_capture) begin
        o_rdata      <= i_mem_rdata;
        o_cpu_rvalid <= (owner == OWN_CPU);
        o_dbg_rvalid <= (owner == OWN_DBG);
      end

      case (state)
        IDLE: begin
          if (pick_valid) begin
            state       <= ISSUE;
            owner       <= pick_owner;
            o_cpu_gnt   <= (pick_owner == OWN_CPU);
            o_dbg_gnt   <= (pick_owner == OWN_DBG);
            o_mem_write <= sel_we;
            o_mem_read  <= !sel_we;
            o_mem_addr  <= sel_addr;
            o_mem_wdata <= sel_wdata;
            lat_cnt     <= sel_we ? 2'd0 : RD_LAT_W;
          end
        end
        ISSUE: begin
          if (o_mem_read) begin
            state   <= WAIT_RD;
            lat_cnt <= lat_dec;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_RD: begin
          if (lat_cnt == 2'd0) begin
            state <= IDLE;
          end else begin
            lat_cnt <= lat_dec;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Counts CPU wins taken while debug was waiting; any debug win or idle debug clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!i_dbg_req || (pick_valid && (pick_owner == OWN_DBG))) begin
        starve_cnt <= '0;
      end else if (pick_valid && (pick_owner == OWN_CPU)) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: RD_LAT=1 instance checked by a monitor,
// plus an RD_LAT=3 instance for latency and mid-read reset.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct {
    bit          is_rv;
    bit          dbg;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          dbg;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] data;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance (RD_LAT = 1)
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata, rdata;
  logic          cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_write, mem_read, busy;
  logic [DW-1:0] mem [256];

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_cpu_gnt(cpu_gnt), .o_dbg_gnt(dbg_gnt), .o_cpu_rvalid(cpu_rvalid), .o_dbg_rvalid(dbg_rvalid),
    .o_rdata(rdata), .o_mem_write(mem_write), .o_mem_read(mem_read), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  // RAM with one cycle from strobe edge to data; garbage outside the valid cycle.
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_read ? mem[mem_addr] : 16'hDEAD;

  // Second instance (RD_LAT = 3), debug port idle
  logic          rst3_extra = 1'b0;
  logic          rst3;
  logic          c3_req, c3_we;
  logic [AW-1:0] c3_addr, m3_addr;
  logic [DW-1:0] c3_wdata, m3_wdata, m3_rdata, r3_rdata;
  logic          z1 = 1'b0;
  logic [AW-1:0] z_addr = '0;
  logic [DW-1:0] z_data = '0;
  logic          g3_cpu, g3_dbg, rv3_cpu, rv3_dbg, m3_write, m3_read, busy3;
  logic [DW-1:0] mem3 [256];
  logic [1:0]    v3 = 2'b00;
  logic [AW-1:0] a3_0, a3_1;

  assign rst3 = rst | rst3_extra;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .STARVE_LIMIT(4)) dut3 (
    .i_clk(clk), .i_rst(rst3),
    .i_cpu_req(c3_req), .i_cpu_we(c3_we), .i_cpu_addr(c3_addr), .i_cpu_wdata(c3_wdata),
    .i_dbg_req(z1), .i_dbg_we(z1), .i_dbg_addr(z_addr), .i_dbg_wdata(z_data),
    .o_cpu_gnt(g3_cpu), .o_dbg_gnt(g3_dbg), .o_cpu_rvalid(rv3_cpu), .o_dbg_rvalid(rv3_dbg),
    .o_rdata(r3_rdata), .o_mem_write(m3_write), .o_mem_read(m3_read), .o_mem_addr(m3_addr),
    .o_mem_wdata(m3_wdata), .i_mem_rdata(m3_rdata), .o_busy(busy3)
  );

  // Three-cycle RAM: data valid two cycles after the strobe cycle.
  always @(posedge clk) begin
    if (m3_write) mem3[m3_addr] <= m3_wdata;
    v3   <= {v3[0], m3_read};
    a3_0 <= m3_addr;
    a3_1 <= a3_0;
  end
  assign m3_rdata = v3[1] ? mem3[a3_1] : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void exp_gnt(input bit dbg, input bit we, input logic [7:0] addr,
                                  input logic [15:0] data, input int at);
    exp_t e;
    e.is_rv = 1'b0; e.dbg = dbg; e.we = we; e.addr = addr; e.data = data; e.cyc = at;
    sb.push_back(e);
  endfunction

  function automatic void exp_rv(input bit dbg, input logic [15:0] data, input int at);
    exp_t e;
    e.is_rv = 1'b1; e.dbg = dbg; e.we = 1'b0; e.addr = '0; e.data = data; e.cyc = at;
    sb.push_back(e);
  endfunction

  // Monitor: pops one expectation per grant or rvalid pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (cpu_gnt || dbg_gnt || mem_read || mem_write)
        check("strobe_with_gnt", mem_read | mem_write, cpu_gnt | dbg_gnt);
      if (cpu_gnt || dbg_gnt || cpu_rvalid || dbg_rvalid) begin
        check("sb_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("event_kind", cpu_rvalid | dbg_rvalid, e.is_rv);
          check("event_cycle", cyc, e.cyc);
          if (e.is_rv) begin
            check("rv_owner", {dbg_rvalid, cpu_rvalid}, e.dbg ? 2'b10 : 2'b01);
            check("rv_data", rdata, e.data);
          end else begin
            check("gnt_owner", {dbg_gnt, cpu_gnt}, e.dbg ? 2'b10 : 2'b01);
            check("gnt_strobe", {mem_write, mem_read}, e.we ? 2'b10 : 2'b01);
            check("gnt_addr", mem_addr, e.addr);
            if (e.we) check("gnt_wdata", mem_wdata, e.data);
            check("gnt_busy", busy, 1);
          end
        end
      end
    end
  end

  task automatic wait_gnt(input bit dbg);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (dbg ? dbg_gnt : cpu_gnt) return;
    end
    check("gnt_timeout", dbg ? dbg_gnt : cpu_gnt, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    check("idle_timeout", busy, 0);
  endtask

  // Holds cpu_req across count consecutive operations, advancing after each grant.
  task automatic cpu_burst(input bit we, input int count, input logic [7:0] base,
                           input logic [15:0] dbase);
    cpu_we  = we;
    cpu_req = 1'b1;
    for (int i = 0; i < count; i++) begin
      cpu_addr  = base + 8'(i);
      cpu_wdata = dbase + 16'(i);
      wait_gnt(1'b0);
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
  endtask

  task automatic dbg_op(input bit we, input logic [7:0] addr, input logic [15:0] wdata);
    dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    wait_gnt(1'b1);
    @(posedge clk); #1;
    dbg_req = 1'b0;
  endtask

  op_t ops [8] = '{
    '{1'b0, 1'b1, 8'h00, 16'h0001},
    '{1'b0, 1'b1, 8'hFF, 16'hA5A5},
    '{1'b1, 1'b1, 8'h34, 16'h1234},
    '{1'b0, 1'b0, 8'hFF, 16'hA5A5},
    '{1'b0, 1'b0, 8'h34, 16'h1234},
    '{1'b1, 1'b0, 8'h00, 16'h0001},
    '{1'b0, 1'b1, 8'h12, 16'h5A5A},
    '{1'b1, 1'b0, 8'h12, 16'h5A5A}
  };

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int seen;
    foreach (mem[i]) begin mem[i] = '0; mem3[i] = '0; end
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    c3_req = 0; c3_we = 0; c3_addr = '0; c3_wdata = '0;
    rst = 1'b0;
    #1 rst = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_flags", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_write, mem_read, busy}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", {busy, cpu_gnt, dbg_gnt, mem_read, mem_write}, 0);

    // CPU write 0x12 <- 0xBEEF: gnt at N+1, idle at N+2
    n = cyc;
    exp_gnt(1'b0, 1'b1, 8'h12, 16'hBEEF, n + 1);
    cpu_burst(1'b1, 1, 8'h12, 16'hBEEF);
    check("wr_idle_n2", busy, 0);

    // Debug read 0x12: gnt N+1, rvalid N+2, idle N+3
    n = cyc;
    exp_gnt(1'b1, 1'b0, 8'h12, 16'h0, n + 1);
    exp_rv(1'b1, 16'hBEEF, n + 2);
    dbg_op(1'b0, 8'h12, 16'h0);
    check("rd_busy_n2", busy, 1);
    @(posedge clk); #1;
    check("rd_idle_n3", busy, 0);
    check("rdata_hold", rdata, 16'hBEEF);

    // Directed op table, including the 0x00/0xFF address boundaries
    foreach (ops[i]) begin
      n = cyc;
      exp_gnt(ops[i].dbg, ops[i].we, ops[i].addr, ops[i].we ? ops[i].data : 16'h0, n + 1);
      if (!ops[i].we) exp_rv(ops[i].dbg, ops[i].data, n + 2);
      if (ops[i].dbg) dbg_op(ops[i].we, ops[i].addr, ops[i].data);
      else            cpu_burst(ops[i].we, 1, ops[i].addr, ops[i].data);
      wait_idle();
    end

    // Back-to-back CPU writes: one grant per 2 cycles
    n = cyc;
    for (int i = 0; i < 3; i++) exp_gnt(1'b0, 1'b1, 8'h50 + 8'(i), 16'hC000 + 16'(i), n + 1 + 2 * i);
    cpu_burst(1'b1, 3, 8'h50, 16'hC000);
    wait_idle();

    // Simultaneous requests: CPU first, then debug once CPU lets go
    n = cyc;
    exp_gnt(1'b0, 1'b1, 8'h40, 16'h1111, n + 1);
    exp_gnt(1'b1, 1'b0, 8'h12, 16'h0, n + 3);
    exp_rv(1'b1, 16'h5A5A, n + 4);
    fork
      cpu_burst(1'b1, 1, 8'h40, 16'h1111);
      dbg_op(1'b0, 8'h12, 16'h0);
    join
    wait_idle();

    // Debug request withdrawn while the CPU write is in ISSUE
    n = cyc;
    exp_gnt(1'b0, 1'b1, 8'h41, 16'h2222, n + 1);
    dbg_we = 1'b0; dbg_addr = 8'h41; dbg_req = 1'b1;
    fork
      cpu_burst(1'b1, 1, 8'h41, 16'h2222);
      begin @(posedge clk); #1 dbg_req = 1'b0; end
    join
    check("withdraw_idle", busy, 0);
    repeat (4) @(posedge clk);
    #1 check("withdraw_still_idle", busy, 0);

    // CPU streaming writes with a debug read pending
    n = cyc;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) exp_gnt(1'b0, 1'b1, 8'h60 + 8'(i), 16'hD000 + 16'(i), n + 1 + 2 * i);
    exp_gnt(1'b1, 1'b0, 8'h50, 16'h0, n + 9);
    exp_rv(1'b1, 16'hC000, n + 10);
    exp_gnt(1'b0, 1'b1, 8'h64, 16'hD004, n + 12);
    exp_gnt(1'b0, 1'b1, 8'h65, 16'hD005, n + 14);
`else
    for (int i = 0; i < 6; i++) exp_gnt(1'b0, 1'b1, 8'h60 + 8'(i), 16'hD000 + 16'(i), n + 1 + 2 * i);
    exp_gnt(1'b1, 1'b0, 8'h50, 16'h0, n + 13);
    exp_rv(1'b1, 16'hC000, n + 14);
`endif
    fork
      cpu_burst(1'b1, 6, 8'h60, 16'hD000);
      dbg_op(1'b0, 8'h50, 16'h0);
    join
    wait_idle();
    repeat (4) @(posedge clk);
    #1 check("sb_drained", sb.size(), 0);

    // RD_LAT = 3: write, then read with rvalid at N+4 and idle at N+5
    c3_we = 1'b1; c3_addr = 8'h21; c3_wdata = 16'h3C3C; c3_req = 1'b1;
    @(posedge clk); #1;
    check("l3_wr_gnt", {g3_cpu, m3_write, m3_read}, 3'b110);
    c3_req = 1'b0;
    @(posedge clk); #1;
    check("l3_wr_idle", busy3, 0);
    c3_we = 1'b0; c3_req = 1'b1;
    @(posedge clk); #1;
    check("l3_rd_gnt", {g3_cpu, m3_write, m3_read}, 3'b101);
    check("l3_rd_addr", m3_addr, 8'h21);
    c3_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("l3_rvalid", rv3_cpu, (k == 3) ? 1 : 0);
      check("l3_busy", busy3, (k == 4) ? 0 : 1);
      if (k == 3) check("l3_rdata", r3_rdata, 16'h3C3C);
    end

    // Reset during WAIT_RD: outputs clear at once, the read never completes
    c3_req = 1'b1;
    @(posedge clk); #1 c3_req = 1'b0;
    @(posedge clk); #1;
    check("l3_in_wait", busy3, 1);
    rst3_extra = 1'b1;
    #1;
    check("l3_rst_flags", {g3_cpu, g3_dbg, rv3_cpu, rv3_dbg, m3_write, m3_read, busy3}, 0);
    check("l3_rst_rdata", r3_rdata, 0);
    check("l3_rst_addr", m3_addr, 0);
    seen = 0;
    repeat (2) begin @(negedge clk); seen += int'(rv3_cpu | rv3_dbg); end
    @(posedge clk); #1 rst3_extra = 1'b0;
    repeat (5) begin @(negedge clk); seen += int'(rv3_cpu | rv3_dbg | m3_read); end
    check("l3_no_rvalid", seen, 0);
    check("l3_idle_after_rst", busy3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single data RAM on the external bus. It shares the RAM between the CPU port (the MAR/MBR path driven by the control unit) and a debug port (the user-interface readback/poke path). It serialises the two streams, drives the RAM read/write strobes and returns read data with a valid pulse. It sits between the external bus and the data RAM, alongside the CPU top.

## Interface
Parameters:
- AW, 8: address width (data RAM depth 2^AW words).
- DW, 16: data width.
- RD_LAT, 1: RAM read latency in cycles from the strobe edge to valid data; legal range 1..3.
- STARVE_LIMIT, 4: consecutive CPU grants allowed while debug waits (guard build only); legal range 1..15.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_cpu_req / i_dbg_req  in  1  request; held until the matching gnt.
- i_cpu_we / i_dbg_we  in  1  1 = write, 0 = read; held with req.
- i_cpu_addr / i_dbg_addr  in  AW  word address.
- i_cpu_wdata / i_dbg_wdata  in  DW  write data.
- o_cpu_gnt / o_dbg_gnt  out  1  one-cycle accept pulse.
- o_cpu_rvalid / o_dbg_rvalid  out  1  one-cycle read-data-valid pulse.
- o_rdata  out  DW  read data, shared by both ports; qualified by the rvalid pulses.
- o_mem_write / o_mem_read  out  1  RAM strobes, registered.
- o_mem_addr  out  AW  RAM address, registered.
- o_mem_wdata  out  DW  RAM write data, registered.
- i_mem_rdata  in  DW  RAM read data.
- o_busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE: arbitrates among asserted requests and latches the winner's owner, we, addr and wdata. Transitions to ISSUE on the next edge. With no request it stays in IDLE.
- Arbitration: CPU wins when both requests are asserted. The guard (see Configuration) can override this.
- ISSUE, lasts exactly one cycle:
  - Asserts the winner's gnt.
  - Drives o_mem_addr and o_mem_wdata.
  - Asserts o_mem_write if we = 1, otherwise o_mem_read.
  - A write returns to IDLE. A read goes to WAIT_RD with the latency counter loaded with RD_LAT.
- WAIT_RD:
  - The counter decrements each cycle.
  - At zero, i_mem_rdata is captured into o_rdata and the owner's rvalid pulses for one cycle; the state returns to IDLE in the same cycle.
- Exactly one transaction is in flight at a time. A request is never dropped; it is served on a later arbitration.
- A request deasserted before its gnt is withdrawn with no side effects.
- Requests that change while in ISSUE or WAIT_RD are ignored until the state is back in IDLE.
- o_rdata holds its last captured value between reads.

## Timing
- Reset values: all gnt, rvalid and strobe outputs are 0; o_mem_addr = 0, o_mem_wdata = 0, o_rdata = 0, o_busy = 0; state = IDLE; all counters = 0.
- A request seen in IDLE at cycle N gives gnt and the strobe at cycle N+1.
- Write occupancy is 2 cycles. Maximum write rate is one per 2 cycles.
- For a read, rvalid arrives at cycle N+1+RD_LAT and the arbiter is back in IDLE at cycle N+2+RD_LAT.
- Reset mid-transaction: outputs clear immediately and asynchronously. A pending read is abandoned with no rvalid. A requester must re-request after reset release.
- Address arithmetic: none. Addresses pass through unmodified, with no wrap or range checking.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments on each CPU grant made while i_dbg_req is high.
  - When the counter equals STARVE_LIMIT, the next arbitration with i_dbg_req high grants debug even if the CPU is requesting.
  - The counter clears on any debug grant and whenever i_dbg_req is low in IDLE.
- MEM_ARB_STARVE_GUARD_EN undefined: strict CPU priority, and the counter logic is absent.

## Structure
- Shared package `mem_arb_pkg`:
  - The state enum (IDLE, ISSUE, WAIT_RD).
  - The owner encoding (OWN_CPU = 0, OWN_DBG = 1).
  - The default AW/DW constants, matching the external-bus widths.
- One sub-module, `mem_arb_pick`: combinational winner select covering both requests, the guard counter state and the owner output. Everything else lives in the top of the block.

## Test plan
- CPU write with addr 0x12 and wdata 0xBEEF from IDLE → at N+1: o_cpu_gnt = 1, o_mem_write = 1, o_mem_addr = 0x12, o_mem_wdata = 0xBEEF; at N+2: o_busy = 0.
- Debug read of addr 0x12 after that write, RD_LAT = 1 → o_dbg_gnt at N+1; o_dbg_rvalid at N+2 with o_rdata = 0xBEEF; o_cpu_rvalid stays 0.
- Both requests asserted simultaneously, guard disabled → CPU is granted first; debug is granted on the following arbitration once CPU deasserts.
- Guard enabled, STARVE_LIMIT = 4, CPU writes continuously, debug read pending → CPU receives 4 grants, then debug receives the 5th grant, then the CPU resumes.
- i_rst pulsed during WAIT_RD with RD_LAT = 3 → no rvalid pulse; all outputs are 0 during reset; state is IDLE after release.
- Debug request dropped while a CPU write is in ISSUE → no debug gnt, no RAM strobe for debug, and o_busy low after the CPU write completes.
